// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch stage feeding the control unit.
// Owns the PC, drives the synchronous program ROM address, absorbs the
// ROM's one-cycle read latency and hands each instruction to the UC
// over a valid/ready handshake. A consumed HALT opcode stops fetch until reset.
module busca_instrucao #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                OPC_W    = 4,
    parameter logic [OPC_W-1:0]  HALT_OPC = 4'hF
) (
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  a_rom,
    input  logic [INSTR_W-1:0] data_rom,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  pc_atual,
    output logic               halted
);

    typedef enum logic [1:0] {
        BUSCA   = 2'd0,
        ESPERA  = 2'd1,
        ENTREGA = 2'd2,
        PARADO  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic [ADDR_W-1:0]   r_pc_atual;
    logic                r_instr_valid;
    logic                r_halted;

    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [INSTR_W-1:0]  w_instr_nxt;
    logic [ADDR_W-1:0]   w_pc_atual_nxt;
    logic                w_instr_valid_nxt;
    logic                w_halted_nxt;

    logic                w_accept;
    logic                w_is_halt;
    logic [ADDR_W-1:0]   w_pc_inc;

    // Handshake only counts while an instruction is actually on offer.
    assign w_accept  = (r_state == ENTREGA) & r_instr_valid & instr_ready;
    assign w_is_halt = (r_instr[INSTR_W-1 -: OPC_W] == HALT_OPC);
    // Sequential successor; natural overflow gives the modulo wrap.
    assign w_pc_inc  = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    // State register and all datapath registers; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= BUSCA;
            r_pc          <= {ADDR_W{1'b0}};
            r_instr       <= {INSTR_W{1'b0}};
            r_pc_atual    <= {ADDR_W{1'b0}};
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_pc_atual    <= w_pc_atual_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    // Next-state logic: fetch, wait for ROM, deliver, or stay stopped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BUSCA:   w_state_nxt = ESPERA;
            ESPERA:  w_state_nxt = ENTREGA;
            ENTREGA: begin
                if (w_accept) begin
                    if (w_is_halt) begin
                        w_state_nxt = PARADO;
                    end else begin
                        w_state_nxt = BUSCA;
                    end
                end else begin
                    w_state_nxt = ENTREGA;
                end
            end
            PARADO:  w_state_nxt = PARADO;
            default: w_state_nxt = BUSCA;
        endcase
    end

    // Output/datapath next values; anything not touched holds its value.
    always_comb begin
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_pc_atual_nxt    = r_pc_atual;
        w_instr_valid_nxt = r_instr_valid;
        w_halted_nxt      = r_halted;
        case (r_state)
            BUSCA: begin
                w_instr_valid_nxt = 1'b0;
            end
            ESPERA: begin
                // ROM data now reflects the address issued in BUSCA.
                w_instr_nxt       = data_rom;
                w_pc_atual_nxt    = r_pc;
                w_instr_valid_nxt = 1'b1;
            end
            ENTREGA: begin
                if (w_accept) begin
                    w_instr_valid_nxt = 1'b0;
                    if (w_is_halt) begin
                        // HALT takes precedence over a simultaneous jump.
                        w_halted_nxt = 1'b1;
                    end else if (jump_en) begin
                        w_pc_nxt = jump_addr;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end else begin
                    w_instr_valid_nxt = r_instr_valid;
                end
            end
            PARADO: begin
                w_instr_valid_nxt = 1'b0;
                w_halted_nxt      = 1'b1;
            end
            default: begin
                w_instr_valid_nxt = 1'b0;
            end
        endcase
    end

    assign a_rom       = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_atual    = r_pc_atual;
    assign halted      = r_halted;

endmodule

// File: tb/tb_busca_instrucao.sv
// Testbench for busca_instrucao: directed vector table, hand-written corner
// sequences and a randomized phase, all checked against a transaction-level model.
module tb_busca_instrucao;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  a_rom;
    logic [15:0] data_rom = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        jump_en = 1'b0;
    logic [7:0]  jump_addr = 8'h00;
    logic [7:0]  pc_atual;
    logic        halted;

    logic [15:0] rom [0:255];

    int n_total = 0;
    int n_pass  = 0;

    // Model: PC, edges since last accept/reset, and the delivered instruction.
    logic [7:0]  m_pc       = 8'h00;
    int          m_cnt      = 0;
    logic        m_valid    = 1'b0;
    logic        m_halted   = 1'b0;
    logic [15:0] m_instr    = 16'h0000;
    logic [7:0]  m_pc_atual = 8'h00;

    busca_instrucao dut (
        .clock       (clock),
        .reset       (reset),
        .a_rom       (a_rom),
        .data_rom    (data_rom),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .pc_atual    (pc_atual),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clock) data_rom <= rom[a_rom];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic step(input logic rst, input logic rdy, input logic je, input logic [7:0] ja);
        reset = rst; instr_ready = rdy; jump_en = je; jump_addr = ja;
        @(posedge clock);
        if (rst) begin
            m_pc = 8'h00; m_cnt = 0; m_valid = 1'b0; m_halted = 1'b0;
            m_instr = 16'h0000; m_pc_atual = 8'h00;
        end else if (!m_halted) begin
            if (m_valid) begin
                if (rdy) begin
                    m_valid = 1'b0;
                    m_cnt   = 0;
                    if (m_instr[15:12] == 4'hF) m_halted = 1'b1;
                    else if (je)                m_pc = ja;
                    else                        m_pc = m_pc + 8'd1;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 2) begin
                    m_valid    = 1'b1;
                    m_instr    = rom[m_pc];
                    m_pc_atual = m_pc;
                end
            end
        end
        #1;
        chk("model_a_rom",  {24'd0, a_rom},      {24'd0, m_pc});
        chk("model_valid",  {31'd0, instr_valid},{31'd0, m_valid});
        chk("model_halted", {31'd0, halted},     {31'd0, m_halted});
        chk("model_instr",  {16'd0, instr},      {16'd0, m_instr});
        chk("model_pc_at",  {24'd0, pc_atual},   {24'd0, m_pc_atual});
    endtask

    typedef struct {
        logic        rst, rdy, je;
        logic [7:0]  ja;
        logic [7:0]  e_a;
        logic        e_v;
        logic [15:0] e_i;
        logic [7:0]  e_p;
        logic        e_h;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic [7:0] e_a,
                                input logic e_v, input logic [15:0] e_i, input logic [7:0] e_p);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.je = 1'b0; v.ja = 8'h00;
        v.e_a = e_a; v.e_v = e_v; v.e_i = e_i; v.e_p = e_p; v.e_h = 1'b0;
        return v;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    endtask

    initial begin
        int k;
        clear_rom();
        rom[0] = 16'h1005; rom[1] = 16'h1003; rom[2] = 16'h2000;

        // Sequential fetch with ready held high, then a 5-clock stall on ROM[0].
        tbl.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 16'h1005, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b0, 16'h1005, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b0, 16'h1005, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b1, 16'h1003, 8'h01));
        tbl.push_back(mk(1'b0, 1'b1, 8'h02, 1'b0, 16'h1003, 8'h01));
        tbl.push_back(mk(1'b0, 1'b1, 8'h02, 1'b0, 16'h1003, 8'h01));
        tbl.push_back(mk(1'b0, 1'b1, 8'h02, 1'b1, 16'h2000, 8'h02));
        tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 16'h1005, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b0, 16'h1005, 8'h00));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rdy, tbl[i].je, tbl[i].ja);
            chk($sformatf("vec%0d_a_rom", i),  {24'd0, a_rom},       {24'd0, tbl[i].e_a});
            chk($sformatf("vec%0d_valid", i),  {31'd0, instr_valid}, {31'd0, tbl[i].e_v});
            chk($sformatf("vec%0d_instr", i),  {16'd0, instr},       {16'd0, tbl[i].e_i});
            chk($sformatf("vec%0d_pc_at", i),  {24'd0, pc_atual},    {24'd0, tbl[i].e_p});
            chk($sformatf("vec%0d_halted", i), {31'd0, halted},      {31'd0, tbl[i].e_h});
        end

        // Jump taken at PC=3; jump pulses while nothing is valid are ignored.
        clear_rom();
        rom[8'h40] = 16'h4444;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        k = 0;
        while (!(m_valid && m_pc == 8'h40) && k < 60) begin
            if (m_valid) step(1'b0, 1'b1, (m_pc == 8'h03), 8'h40);
            else         step(1'b0, 1'b1, 1'b1, 8'h77);
            k++;
        end
        chk("jump_timeout", {31'd0, (k < 60)}, 32'd1);
        chk("jump_a_rom",   {24'd0, a_rom},    32'h40);
        chk("jump_pc_at",   {24'd0, pc_atual}, 32'h40);
        chk("jump_instr",   {16'd0, instr},    32'h4444);

        // HALT at ROM[2] with jump_en on the same accept: halt wins, PC frozen.
        clear_rom();
        rom[2] = 16'hF000;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        k = 0;
        while (!m_halted && k < 40) begin
            step(1'b0, 1'b1, (m_pc == 8'h02), 8'h99);
            k++;
        end
        chk("halt_timeout", {31'd0, (k < 40)}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            chk("halt_a_rom",  {24'd0, a_rom},       32'h02);
            chk("halt_valid",  {31'd0, instr_valid}, 32'd0);
            chk("halt_halted", {31'd0, halted},      32'd1);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("halt_rst_a_rom",  {24'd0, a_rom},  32'h00);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);

        // Jump to 0xFF, then sequential accept wraps PC to 0x00.
        clear_rom();
        rom[8'hFF] = 16'h1234;
        k = 0;
        while (!(m_valid && m_pc == 8'hFF) && k < 20) begin
            step(1'b0, 1'b1, 1'b1, 8'hFF);
            k++;
        end
        chk("wrap_timeout", {31'd0, (k < 20)}, 32'd1);
        chk("wrap_instr",   {16'd0, instr},    32'h1234);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("wrap_a_rom",   {24'd0, a_rom},    32'h00);

        // Reset in the middle of a pending handshake discards the instruction.
        k = 0;
        while (!m_valid && k < 10) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            k++;
        end
        chk("mid_timeout", {31'd0, (k < 10)}, 32'd1);
        step(1'b1, 1'b1, 1'b1, 8'h33);
        chk("mid_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_instr", {16'd0, instr},       32'h0000);
        chk("mid_a_rom", {24'd0, a_rom},       32'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("mid_lat1", {31'd0, instr_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("mid_lat2", {31'd0, instr_valid}, 32'd1);

        // Randomized traffic with occasional HALTs and resets.
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'($urandom);
            if ($urandom_range(0, 9) == 0) rom[i][15:12] = 4'hF;
            else if (rom[i][15:12] == 4'hF) rom[i][15:12] = 4'h1;
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_halted) k++;
            else          k = 0;
            step((k > 15) || ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0),
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
